// File: rtl/switch_pkg.sv
// Shared constants and helpers for the switch debouncer.
package switch_pkg;

    localparam int NUM_SWITCHES         = 16;
    localparam int DEFAULT_STABLE_COUNT = 1_000_000;

    // Stability counter width; at least one bit so tiny counts still elaborate.
    function automatic int cnt_width(input int stable_count);
        int w;
        w = $clog2(stable_count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_debouncer_bit.sv
// One debounce channel: two-flop synchronizer, stability counter and accepted level.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic level_out
);

    localparam int            CW       = cnt_width(STABLE_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accepting at CNT_LAST also clears the counter, so it can never wrap.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            meta_q  <= raw_in;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel slide-switch debouncer with optional registered edge pulses.
// Edge pulses exist only when SWITCH_DEBOUNCER_EDGE_EN is defined; otherwise they read 0.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH        = NUM_SWITCHES,
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] switches_inputs,
    output logic [WIDTH-1:0] switches_outputs,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    logic [WIDTH-1:0] level;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_COUNT(STABLE_COUNT)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_in   (switches_inputs[i]),
            .level_out(level[i])
        );
    end

    assign switches_outputs = level;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             any_q;
    logic             any_d;

    // Pulses land in the cycle after the debounced level changes.
    always_comb begin
        rise_d = level & ~prev_q;
        fall_d = ~level & prev_q;
        any_d  = (|rise_d) | (|fall_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            prev_q <= level;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
    assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer (WIDTH=16, STABLE_COUNT=4).
module tb_switch_debouncer;

    localparam int W  = 16;
    localparam int SC = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  sw_in;
    logic [W-1:0]  sw_out;
    logic [W-1:0]  rise;
    logic [W-1:0]  fall;
    logic          any;

    int checks = 0;
    int errors = 0;
    int rise_cnt[W];
    int fall_cnt[W];
    int any_cnt;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH       (W),
        .STABLE_COUNT(SC)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .switches_inputs (sw_in),
        .switches_outputs(sw_out),
        .rise_pulse      (rise),
        .fall_pulse      (fall),
        .any_change      (any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        any_cnt = 0;
    endtask

    // Advance one rising edge, then sample on the following falling edge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            if (rise[i] === 1'b1) rise_cnt[i]++;
            if (fall[i] === 1'b1) fall_cnt[i]++;
        end
        if (any === 1'b1) any_cnt++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic int other_rises(input int b);
        int s;
        s = 0;
        for (int i = 0; i < W; i++) if (i != b) s += rise_cnt[i];
        return s;
    endfunction

    initial begin
        reset_n = 1'b0;
        sw_in   = 16'hFFFF;
        clr_cnt();
        @(negedge clk);
        steps(3);
        chk("rst_out",  32'(sw_out), 32'h0);
        chk("rst_rise", 32'(rise),   32'h0);
        chk("rst_fall", 32'(fall),   32'h0);
        chk("rst_any",  32'(any),    32'h0);

        // Release with all inputs high: accept after 2+SC edges, pulse one cycle later.
        reset_n = 1'b1;
        steps(5);
        chk("rel_out_e5", 32'(sw_out), 32'h0);
        step();
        chk("rel_out_e6",  32'(sw_out), 32'hFFFF);
        chk("rel_rise_e6", 32'(rise),   32'h0);
        step();
        chk("rel_rise_e7", 32'(rise), 32'(EDGE ? 16'hFFFF : 16'h0));
        chk("rel_any_e7",  32'(any),  32'(EDGE));
        step();
        chk("rel_rise_e8", 32'(rise), 32'h0);
        chk("rel_any_e8",  32'(any),  32'h0);

        // All inputs low.
        clr_cnt();
        sw_in = 16'h0000;
        steps(8);
        chk("low_out",    32'(sw_out),      32'h0);
        chk("low_fall0",  32'(fall_cnt[0]), 32'(EDGE ? 1 : 0));
        chk("low_fall15", 32'(fall_cnt[15]), 32'(EDGE ? 1 : 0));

        // Bounce on bit 3: 0,1,0,1,1,1,1,1.
        clr_cnt();
        begin
            logic [7:0] vec;
            vec = 8'hFA;
            for (int i = 0; i < 8; i++) begin
                sw_in[3] = vec[i];
                step();
            end
        end
        chk("bnc_hold", 32'(sw_out), 32'h0);
        step();
        chk("bnc_acc", 32'(sw_out), 32'h0008);
        steps(3);
        chk("bnc_rise3",  32'(rise_cnt[3]),   32'(EDGE ? 1 : 0));
        chk("bnc_other",  32'(other_rises(3)), 32'h0);
        chk("bnc_fall3",  32'(fall_cnt[3]),   32'h0);

        // Simultaneous rise on bit 0 and fall on bit 15.
        sw_in = 16'h8008;
        steps(10);
        chk("sim_pre", 32'(sw_out), 32'h8008);
        clr_cnt();
        sw_in = 16'h0009;
        steps(5);
        chk("sim_e5", 32'(sw_out), 32'h8008);
        step();
        chk("sim_e6",      32'(sw_out), 32'h0009);
        chk("sim_e6_rise", 32'(rise),   32'h0);
        chk("sim_e6_fall", 32'(fall),   32'h0);
        step();
        chk("sim_e7_rise", 32'(rise), 32'(EDGE ? 16'h0001 : 16'h0));
        chk("sim_e7_fall", 32'(fall), 32'(EDGE ? 16'h8000 : 16'h0));
        chk("sim_e7_any",  32'(any),  32'(EDGE));
        step();
        chk("sim_e8_rise", 32'(rise), 32'h0);
        chk("sim_e8_fall", 32'(fall), 32'h0);
        chk("sim_e8_any",  32'(any),  32'h0);

        // Reset mid-count on bit 7 abandons the change.
        clr_cnt();
        sw_in = 16'h0089;
        steps(4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out",  32'(sw_out), 32'h0);
        chk("mid_rst_rise", 32'(rise),   32'h0);
        chk("mid_rst_fall", 32'(fall),   32'h0);
        chk("mid_rst_any",  32'(any),    32'h0);
        sw_in = 16'h0009;
        steps(2);
        reset_n = 1'b1;
        steps(5);
        chk("mid_e5", 32'(sw_out), 32'h0);
        step();
        chk("mid_e6", 32'(sw_out), 32'h0009);
        steps(4);
        chk("mid_rise7", 32'(rise_cnt[7]), 32'h0);
        chk("mid_fall7", 32'(fall_cnt[7]), 32'h0);
        chk("mid_rise0", 32'(rise_cnt[0]), 32'(EDGE ? 1 : 0));
        chk("mid_rise3", 32'(rise_cnt[3]), 32'(EDGE ? 1 : 0));

        // Long hold on bit 5: one accept, one pulse.
        clr_cnt();
        sw_in = 16'h0029;
        steps(5);
        chk("hold_e5", 32'(sw_out), 32'h0009);
        step();
        chk("hold_e6", 32'(sw_out), 32'h0029);
        steps(94);
        chk("hold_out",   32'(sw_out),         32'h0029);
        chk("hold_rise5", 32'(rise_cnt[5]),    32'(EDGE ? 1 : 0));
        chk("hold_other", 32'(other_rises(5)), 32'h0);
        chk("hold_any",   32'(any_cnt),        32'(EDGE ? 1 : 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of switch channels.
REQ-002 The block SHALL have parameter STABLE_COUNT, default 1_000_000 (10 ms at 100 MHz), giving the consecutive stable cycles required before accepting a change; legal range is 2 to 2^24.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port switches_inputs, input, WIDTH bits: raw, asynchronous, bouncing slide-switch levels.
REQ-006 The block SHALL have port switches_outputs, output, WIDTH bits: debounced levels, which feed switch_logic directly.
REQ-007 The block SHALL have port rise_pulse, output, WIDTH bits: one-cycle pulse per channel when its debounced level goes 0->1.
REQ-008 The block SHALL have port fall_pulse, output, WIDTH bits: one-cycle pulse per channel when its debounced level goes 1->0.
REQ-009 The block SHALL have port any_change, output, 1 bit: the OR of all rise_pulse and fall_pulse bits.

Function
REQ-010 Each channel SHALL pass through a two-flop synchronizer; sync_q is the second flop.
REQ-011 Each channel SHALL keep a counter of width $clog2(STABLE_COUNT) that is cleared in any cycle where sync_q equals the debounced level.
REQ-012 While sync_q differs from the debounced level, the counter SHALL increment by 1 per cycle.
REQ-013 The debounced level SHALL load sync_q, and the counter SHALL clear, on the edge where the counter equals STABLE_COUNT-1 and sync_q still differs.
REQ-014 A clean input step SHALL therefore reach switches_outputs exactly 2+STABLE_COUNT cycles after the first sampling edge.
REQ-015 Any bounce that returns sync_q to the debounced level before acceptance SHALL clear the counter, so that the count restarts from 0.
REQ-016 The counter SHALL never wrap: it saturates at STABLE_COUNT-1, and only at that value does the accept of REQ-013 occur.
REQ-017 Each rise_pulse/fall_pulse bit SHALL be registered and asserted for exactly the one cycle after its debounced level changes.
REQ-018 Channels SHALL be fully independent, and simultaneous changes on several channels SHALL each produce their own pulse in the same cycle.

Reset
REQ-019 Asserting reset_n low SHALL immediately clear the synchronizers, counters, switches_outputs, rise_pulse, fall_pulse and any_change to 0, regardless of clk.
REQ-020 A reset asserted mid-count SHALL abandon the pending change.
REQ-021 After reset deassertion, an input held at 1 SHALL be accepted after 2+STABLE_COUNT cycles and SHALL produce a rise_pulse.

Configuration
REQ-022 Macro SWITCH_DEBOUNCER_EDGE_EN SHALL control the edge detection logic.
REQ-023 With SWITCH_DEBOUNCER_EDGE_EN defined, rise_pulse, fall_pulse and any_change SHALL behave as in REQ-007 to REQ-009 and REQ-017.
REQ-024 Without SWITCH_DEBOUNCER_EDGE_EN, the ports SHALL remain present but be tied to constant 0, with no edge registers synthesized; switches_outputs SHALL be unaffected.

Structure
REQ-025 Package switch_pkg SHALL hold the constants NUM_SWITCHES=16 and DEFAULT_STABLE_COUNT=1_000_000.
REQ-026 Package switch_pkg SHALL also hold the function computing counter width.
REQ-027 The per-channel synchronizer, counter and level register SHALL be a sub-module, debounce_bit, instantiated WIDTH times with a generate loop.
REQ-028 Edge detection and any_change SHALL reside in switch_debouncer.

Verification (bench uses STABLE_COUNT=4, WIDTH=16)
REQ-029 Hold reset_n=0 with switches_inputs=16'hFFFF: all outputs SHALL be 0; release reset: switches_outputs=16'hFFFF exactly 6 cycles later, rise_pulse=16'hFFFF for 1 cycle, any_change=1 for 1 cycle.
REQ-030 Toggle bit 3 as 0,1,0,1,1,1,1,1 on successive cycles: switches_outputs[3] SHALL rise only after the final four-plus-two stable cycles, with exactly one rise_pulse[3].
REQ-031 Step bit 0 up and bit 15 down on the same edge: rise_pulse[0] and fall_pulse[15] SHALL both assert in the same single cycle, with no other pulses.
REQ-032 Step bit 7 to 1, then assert reset_n low after 2 counting cycles and release it with the input returned to 0: switches_outputs[7] SHALL stay 0 with no pulse.
REQ-033 Hold bit 5 high for 100 cycles: the counter SHALL never exceed 3, and rise_pulse[5] SHALL fire exactly once.
REQ-034 Rebuild without SWITCH_DEBOUNCER_EDGE_EN and rerun the REQ-029 stimulus: the same switches_outputs timing SHALL result, with rise_pulse, fall_pulse and any_change constant 0.
